// File: rtl/bellek_erisim_birimi_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states and lane count.
package bellek_erisim_birimi_pkg;

    localparam logic [1:0] BOYUT_BAYT   = 2'b00;
    localparam logic [1:0] BOYUT_YARIM  = 2'b01;
    localparam logic [1:0] BOYUT_KELIME = 2'b10;

    localparam int SERIT_SAYISI = 4;
    localparam int KELIME_BIT   = 8 * SERIT_SAYISI;

    typedef enum logic [1:0] {
        BOSTA = 2'b00,
        OKU   = 2'b01,
        YAZ   = 2'b10,
        YANIT = 2'b11
    } durum_t;

endpackage

// File: rtl/bellek_erisim_birimi_bayt_hizalayici.sv
// Lane extract + sign/zero extend for loads, lane merge for partial stores (little-endian).
// Purely combinational, zero latency; no flow control.
module bayt_hizalayici
    import bellek_erisim_birimi_pkg::*;
(
    input  logic [KELIME_BIT-1:0] kelime,
    input  logic [1:0]            ofset,
    input  logic [1:0]            boyut,
    input  logic                  isaretsiz,
    input  logic [15:0]           yaz_veri,
    output logic [KELIME_BIT-1:0] yuk_veri,
    output logic [KELIME_BIT-1:0] birlesik
);

    logic [7:0]  bayt;
    logic [15:0] yarim;
    logic [4:0]  bit_ofset;

    assign bit_ofset = {ofset, 3'b000};
    assign bayt      = kelime[bit_ofset +: 8];
    assign yarim     = ofset[1] ? kelime[31:16] : kelime[15:0];

    always_comb begin
        yuk_veri = kelime;
        birlesik = kelime;
        case (boyut)
            BOYUT_BAYT: begin
                yuk_veri = {{24{~isaretsiz & bayt[7]}}, bayt};
                birlesik[bit_ofset +: 8] = yaz_veri[7:0];
            end
            BOYUT_YARIM: begin
                yuk_veri = {{16{~isaretsiz & yarim[15]}}, yarim};
                if (ofset[1]) begin
                    birlesik[31:16] = yaz_veri;
                end else begin
                    birlesik[15:0] = yaz_veri;
                end
            end
            default: begin
                yuk_veri = kelime;
                birlesik = kelime;
            end
        endcase
    end

endmodule

// File: rtl/bellek_erisim_birimi.sv
// Single-outstanding load/store unit with read-modify-write for byte/half stores; ADRES_ARALIK_EN adds a window check.
// Latency from accept: error 1, load 2, word store 2, partial store 3 cycles; istek_hazir low until response leaves.
// Backpressure: one request at a time, next accept the cycle after the yanit pulse.
module bellek_erisim_birimi
    import bellek_erisim_birimi_pkg::*;
#(
    parameter int                  ADRES_BIT       = 32,
    parameter int                  VERI_BIT        = 32,
    parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = ADRES_BIT'(32'h8000_0000),
    parameter int                  ERISIM_BOYUT    = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 istek_gecerli,
    output logic                 istek_hazir,
    input  logic                 istek_yaz,
    input  logic [1:0]           istek_boyut,
    input  logic                 istek_isaretsiz,
    input  logic [ADRES_BIT-1:0] istek_adres,
    input  logic [VERI_BIT-1:0]  istek_veri,
    output logic                 yanit_gecerli,
    output logic [VERI_BIT-1:0]  yanit_veri,
    output logic                 yanit_hata,
    output logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz_gecerli
);

    durum_t durum, durum_sonraki;

    logic        kabul;
    logic        hizasiz;
    logic        aralik_hata;
    logic        istek_hata;
    logic        r_yaz;
    logic [1:0]  r_boyut;
    logic [1:0]  r_ofset;
    logic        r_isaretsiz;
    logic [15:0] r_veri;
    logic [VERI_BIT-1:0] yuk_veri;
    logic [VERI_BIT-1:0] birlesik;

    assign kabul = istek_gecerli && (durum == BOSTA);

    always_comb begin
        hizasiz = 1'b0;
        case (istek_boyut)
            BOYUT_BAYT:   hizasiz = 1'b0;
            BOYUT_YARIM:  hizasiz = istek_adres[0];
            BOYUT_KELIME: hizasiz = |istek_adres[1:0];
            default:      hizasiz = 1'b1;
        endcase
    end

`ifdef ADRES_ARALIK_EN
    // Extra top bit catches addresses below the base as a borrow.
    logic [ADRES_BIT:0] aralik_fark;
    assign aralik_fark = {1'b0, istek_adres} - {1'b0, BASLANGIC_ADRES};
    assign aralik_hata = aralik_fark[ADRES_BIT] ||
                         (aralik_fark[ADRES_BIT-1:0] >= ADRES_BIT'(ERISIM_BOYUT));
`else
    assign aralik_hata = 1'b0;
`endif

    assign istek_hata = hizasiz | aralik_hata;

    bayt_hizalayici u_hizalayici (
        .kelime    (bellek_oku_veri),
        .ofset     (r_ofset),
        .boyut     (r_boyut),
        .isaretsiz (r_isaretsiz),
        .yaz_veri  (r_veri),
        .yuk_veri  (yuk_veri),
        .birlesik  (birlesik)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_sonraki;
        end
    end

    always_comb begin
        durum_sonraki      = durum;
        istek_hazir        = 1'b0;
        yanit_gecerli      = 1'b0;
        bellek_yaz_gecerli = 1'b0;
        case (durum)
            BOSTA: begin
                istek_hazir = 1'b1;
                if (istek_gecerli) begin
                    if (istek_hata) begin
                        durum_sonraki = YANIT;
                    end else if (istek_yaz && (istek_boyut == BOYUT_KELIME)) begin
                        durum_sonraki = YAZ;
                    end else begin
                        durum_sonraki = OKU;
                    end
                end
            end
            OKU:     durum_sonraki = r_yaz ? YAZ : YANIT;
            YAZ: begin
                bellek_yaz_gecerli = 1'b1;
                durum_sonraki      = YANIT;
            end
            YANIT: begin
                yanit_gecerli = 1'b1;
                durum_sonraki = BOSTA;
            end
            default: durum_sonraki = BOSTA;
        endcase
    end

    // Rejected requests leave bellek_adres untouched so memory never sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yaz           <= 1'b0;
            r_boyut         <= BOYUT_BAYT;
            r_ofset         <= 2'b00;
            r_isaretsiz     <= 1'b0;
            r_veri          <= '0;
            yanit_veri      <= '0;
            yanit_hata      <= 1'b0;
            bellek_adres    <= '0;
            bellek_yaz_veri <= '0;
        end else if (kabul) begin
            r_yaz       <= istek_yaz;
            r_boyut     <= istek_boyut;
            r_ofset     <= istek_adres[1:0];
            r_isaretsiz <= istek_isaretsiz;
            r_veri      <= istek_veri[15:0];
            yanit_veri  <= '0;
            yanit_hata  <= istek_hata;
            if (!istek_hata) begin
                bellek_adres <= {istek_adres[ADRES_BIT-1:2], 2'b00};
                if (istek_yaz && (istek_boyut == BOYUT_KELIME)) begin
                    bellek_yaz_veri <= istek_veri;
                end
            end
        end else if (durum == OKU) begin
            if (r_yaz) begin
                bellek_yaz_veri <= birlesik;
            end else begin
                yanit_veri <= yuk_veri;
            end
        end
    end

endmodule

// File: tb/tb_bellek_erisim_birimi.sv
// Directed bench for bellek_erisim_birimi with a small word memory and an expected-response queue.
module tb_bellek_erisim_birimi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        istek_gecerli;
    logic        istek_hazir;
    logic        istek_yaz;
    logic [1:0]  istek_boyut;
    logic        istek_isaretsiz;
    logic [31:0] istek_adres;
    logic [31:0] istek_veri;
    logic        yanit_gecerli;
    logic [31:0] yanit_veri;
    logic        yanit_hata;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_oku_veri;
    logic [31:0] bellek_yaz_veri;
    logic        bellek_yaz_gecerli;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] veri;
        logic        hata;
        int          lat;
        int          wcyc;
        logic [31:0] adres;
    } bek_t;
    bek_t q[$];

    logic [31:0] mem [0:511];
    logic        mem_yukle;

    always #5 clk = ~clk;

    bellek_erisim_birimi dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .istek_gecerli      (istek_gecerli),
        .istek_hazir        (istek_hazir),
        .istek_yaz          (istek_yaz),
        .istek_boyut        (istek_boyut),
        .istek_isaretsiz    (istek_isaretsiz),
        .istek_adres        (istek_adres),
        .istek_veri         (istek_veri),
        .yanit_gecerli      (yanit_gecerli),
        .yanit_veri         (yanit_veri),
        .yanit_hata         (yanit_hata),
        .bellek_adres       (bellek_adres),
        .bellek_oku_veri    (bellek_oku_veri),
        .bellek_yaz_veri    (bellek_yaz_veri),
        .bellek_yaz_gecerli (bellek_yaz_gecerli)
    );

    assign bellek_oku_veri = mem[bellek_adres[10:2]];

    always @(posedge clk) begin
        if (mem_yukle) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem[1]   <= 32'h8899_AABB;
            mem[511] <= 32'h0123_4567;
        end else if (bellek_yaz_gecerli) begin
            mem[bellek_adres[10:2]] <= bellek_yaz_veri;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic istek(input string ad, input logic yaz, input logic [1:0] boyut,
                         input logic uns, input logic [31:0] adr, input logic [31:0] veri,
                         input logic [31:0] e_veri, input logic e_hata, input int e_lat,
                         input int e_wcyc);
        bek_t b;
        int   lat;
        int   wcnt;
        int   wcyc;
        @(negedge clk);
        chk({ad, "_hazir"}, {31'b0, istek_hazir}, 32'd1);
        istek_gecerli   = 1'b1;
        istek_yaz       = yaz;
        istek_boyut     = boyut;
        istek_isaretsiz = uns;
        istek_adres     = adr;
        istek_veri      = veri;
        b.veri = e_veri; b.hata = e_hata; b.lat = e_lat; b.wcyc = e_wcyc;
        b.adres = {adr[31:2], 2'b00};
        q.push_back(b);
        @(posedge clk);
        #1;
        // Garbage on the inputs while busy must be ignored.
        istek_gecerli = 1'b0;
        istek_adres   = $urandom;
        istek_veri    = $urandom;
        istek_boyut   = 2'($urandom_range(0, 3));
        lat = 0; wcnt = 0; wcyc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bellek_yaz_gecerli) begin
                wcnt++;
                wcyc = c;
            end
            if (yanit_gecerli) begin
                lat = c;
                break;
            end
        end
        b = q.pop_front();
        chk({ad, "_gecikme"}, lat, b.lat);
        if (lat != 0) begin
            chk({ad, "_veri"}, yanit_veri, b.veri);
            chk({ad, "_hata"}, {31'b0, yanit_hata}, {31'b0, b.hata});
            if (!b.hata) chk({ad, "_adres"}, bellek_adres, b.adres);
        end
        chk({ad, "_yazdongu"}, wcyc, b.wcyc);
        chk({ad, "_yazsayi"}, wcnt, (b.wcyc != 0) ? 1 : 0);
        @(negedge clk);
        chk({ad, "_darbe"}, {31'b0, yanit_gecerli}, 32'd0);
    endtask

    initial begin
        int yaz_say;
        int yanit_say;
        rst_n = 1'b0; mem_yukle = 1'b1;
        istek_gecerli = 1'b0; istek_yaz = 1'b0; istek_boyut = 2'b00;
        istek_isaretsiz = 1'b0; istek_adres = '0; istek_veri = '0;
        repeat (2) @(posedge clk);
        #1 mem_yukle = 1'b0;
        @(negedge clk);
        chk("rst_hazir", {31'b0, istek_hazir}, 32'd1);
        chk("rst_yanit", {31'b0, yanit_gecerli}, 32'd0);
        chk("rst_hata", {31'b0, yanit_hata}, 32'd0);
        chk("rst_veri", yanit_veri, 32'd0);
        chk("rst_badres", bellek_adres, 32'd0);
        chk("rst_byveri", bellek_yaz_veri, 32'd0);
        chk("rst_byg", {31'b0, bellek_yaz_gecerli}, 32'd0);
        rst_n = 1'b1;

        istek("lb",  1'b0, 2'b00, 1'b0, 32'h8000_0005, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 0);
        istek("lhu", 1'b0, 2'b01, 1'b1, 32'h8000_0006, 32'h0, 32'h0000_8899, 1'b0, 2, 0);
        istek("lh",  1'b0, 2'b01, 1'b0, 32'h8000_0006, 32'h0, 32'hFFFF_8899, 1'b0, 2, 0);
        istek("lbu", 1'b0, 2'b00, 1'b1, 32'h8000_0004, 32'h0, 32'h0000_00BB, 1'b0, 2, 0);
        istek("lw",  1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 32'h8899_AABB, 1'b0, 2, 0);

        istek("sb",  1'b1, 2'b00, 1'b0, 32'h8000_0007, 32'h0000_0011, 32'h0, 1'b0, 3, 2);
        chk("sb_bellek", mem[1], 32'h1199_AABB);
        istek("sh",  1'b1, 2'b01, 1'b0, 32'h8000_0004, 32'hFFFF_1234, 32'h0, 1'b0, 3, 2);
        chk("sh_bellek", mem[1], 32'h1199_1234);
        istek("sw",  1'b1, 2'b10, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1);
        chk("sw_bellek", mem[2], 32'hCAFE_F00D);

        istek("sw_hiza", 1'b1, 2'b10, 1'b0, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0);
        chk("sw_hiza_bellek", mem[0], 32'h0);
        istek("lh_hiza", 1'b0, 2'b01, 1'b0, 32'h8000_0005, 32'h0, 32'h0, 1'b1, 1, 0);
        istek("boyut11", 1'b0, 2'b11, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 1'b1, 1, 0);

        // Reset pulse while the partial store is in its read cycle.
        @(negedge clk);
        istek_gecerli = 1'b1; istek_yaz = 1'b1; istek_boyut = 2'b01;
        istek_adres = 32'h8000_0006; istek_veri = 32'h0000_5555;
        @(posedge clk);
        #1 istek_gecerli = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstop_hazir", {31'b0, istek_hazir}, 32'd1);
        chk("rstop_byg", {31'b0, bellek_yaz_gecerli}, 32'd0);
        yaz_say = 0; yanit_say = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bellek_yaz_gecerli) yaz_say++;
            if (yanit_gecerli) yanit_say++;
            if (c == 1) rst_n = 1'b1;
        end
        chk("rstop_yazsayi", yaz_say, 0);
        chk("rstop_yanitsayi", yanit_say, 0);
        chk("rstop_bellek", mem[1], 32'h1199_1234);
        istek("lw_sonra", 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 32'h1199_1234, 1'b0, 2, 0);

`ifdef ADRES_ARALIK_EN
        istek("lw_disari", 1'b0, 2'b10, 1'b0, 32'h8000_0800, 32'h0, 32'h0, 1'b1, 1, 0);
        istek("lw_sinir",  1'b0, 2'b10, 1'b0, 32'h8000_07FC, 32'h0, 32'h0123_4567, 1'b0, 2, 0);
        istek("sw_alti",   1'b1, 2'b10, 1'b0, 32'h7FFF_FFFC, 32'h1111_2222, 32'h0, 1'b1, 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bellek_erisim_birimi.md
Name: bellek_erisim_birimi

Overview:
Initiator-side memory access unit for the multi-cycle RISC-V core. It takes one load/store request at a time from the core, drives the word-addressed main memory port (address, write data, write valid, combinational read data), and returns sign/zero-extended load data or a store completion. Byte and halfword stores use a read-modify-write over two cycles; misaligned requests are rejected without touching memory.

Parameters:
ADRES_BIT, 32, address width of core and memory sides
VERI_BIT, 32, data width; fixed at 32 (4 byte lanes)
BASLANGIC_ADRES, 32'h8000_0000, base of the memory window (used only with ADRES_ARALIK_EN)
ERISIM_BOYUT, 2048, size in bytes of the accepted window above BASLANGIC_ADRES (used only with ADRES_ARALIK_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
istek_gecerli  input  1  core request valid
istek_hazir  output  1  unit can accept a request
istek_yaz  input  1  1 = store, 0 = load
istek_boyut  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as hata)
istek_isaretsiz  input  1  load zero-extends when 1
istek_adres  input  ADRES_BIT  byte address
istek_veri  input  VERI_BIT  store data, right-aligned
yanit_gecerli  output  1  one-cycle pulse: request done
yanit_veri  output  VERI_BIT  extended load data; 0 for stores/errors
yanit_hata  output  1  valid with yanit_gecerli: misaligned/illegal
bellek_adres  output  ADRES_BIT  word-aligned address to memory
bellek_oku_veri  input  VERI_BIT  combinational read data from memory
bellek_yaz_veri  output  VERI_BIT  full word written
bellek_yaz_gecerli  output  1  write strobe, sampled by memory on clk

Behaviour:
- One clock, clk; rst_n asynchronous active-low. Reset: state BOSTA, istek_hazir=1, yanit_gecerli=0, yanit_hata=0, yanit_veri=0, bellek_adres=0, bellek_yaz_veri=0, bellek_yaz_gecerli=0; latched request registers cleared.
- istek_hazir = (state==BOSTA). Handshake: request accepted on rising edge with istek_gecerli&&istek_hazir; all request fields latched then. Inputs ignored outside BOSTA.
- States: BOSTA, OKU, YAZ, YANIT.
- Alignment: half needs adres[0]==0, word needs adres[1:0]==0; boyut 11 illegal. Failing -> BOSTA->YANIT, yanit_hata=1, no memory write.
- Load: BOSTA->OKU->YANIT. In OKU, bellek_adres = {adres[31:2],2'b00}; capture bellek_oku_veri at end of OKU, select lane by adres[1:0] (little-endian), extend per istek_isaretsiz. yanit_gecerli high in YANIT (2 cycles after accept edge).
- Word store: BOSTA->YAZ->YANIT. bellek_yaz_gecerli=1 exactly during YAZ, bellek_yaz_veri=istek_veri.
- Byte/half store: BOSTA->OKU->YAZ->YANIT. OKU captures word; YAZ writes captured word with target lane(s) replaced by istek_veri[7:0]/[15:0].
- YANIT always returns to BOSTA; next request acceptable the cycle after YANIT (1 cycle bubble, no back-to-back overlap).
- bellek_adres holds latched aligned address in OKU/YAZ/YANIT; holds last value in BOSTA. bellek_yaz_gecerli never asserted outside YAZ.
- Reset mid-operation: immediate return to BOSTA; no write completes unless YAZ edge already occurred; no yanit pulse.

Optional Feature:
ADRES_ARALIK_EN: when defined, a request whose address is outside [BASLANGIC_ADRES, BASLANGIC_ADRES+ERISIM_BOYUT) goes BOSTA->YANIT with yanit_hata=1 and no memory access (prevents reading undriven data). When undefined, no range check; parameters unused; only alignment errors flag hata.

Decomposition:
- Shared package: size encodings (BOYUT_BAYT/YARIM/KELIME), state enum, lane-count constant.
- One sub-module: bayt_hizalayici (combinational lane extract/extend for loads and lane merge for stores), reused by OKU capture and YAZ data path.

Test Plan:
- Memory word @0x8000_0004 = 0x8899_AABB; lb 0x8000_0005 signed -> yanit_veri 0xFFFF_FFAA, yanit_gecerli 2 cycles after accept, hata=0.
- lhu 0x8000_0006 -> yanit_veri 0x0000_8899; lw 0x8000_0004 -> 0x8899_AABB.
- sb data 0x0000_0011 @0x8000_0007 -> memory word 0x1199_AABB; bellek_yaz_gecerli high exactly 1 cycle (cycle 2 after accept); yanit cycle 3.
- sw @0x8000_0002 -> yanit_hata=1 one cycle after accept, bellek_yaz_gecerli never high, memory unchanged.
- sh @0x8000_0004, rst_n pulsed low during OKU -> no write, istek_hazir=1 immediately, no yanit pulse; following lw works.
- ADRES_ARALIK_EN defined: lw @0x8000_0800 -> yanit_hata=1, no access; lw @0x8000_07FC -> normal.
